udp_rx_multibuf: RTL and testbench

UDP_RX_MULTIBUF -- requirements
Module: udp_rx_multibuf

---
 rtl/udp_rx_multibuf.sv | 206 ++++++++++++++++++++
 tb/tb_udp_rx_multibuf.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_multibuf.sv
// rtl/udp_rx_multibuf.sv - UDP receive path with checksum verify and multi-slot packet buffer
//
// Ports:
//   clk, rst_n                 single clock, asynchronous active-low reset
//   udp_rx_req                 packet start pulse; L sampled on this cycle
//   udp_rx_data                UDP bytes (8-byte header then payload), one per cycle
//   upper_layer_data_length    L, UDP length including header
//   net_protocol               IP protocol number (pseudo-header)
//   ip_rec_source_addr         IP source address (pseudo-header, stored with slot)
//   ip_rec_destination_addr    IP destination address (pseudo-header)
//   ip_checksum_error          IP header checksum failure, drops the packet
//   ip_addr_check_error        IP address check failure, drops the packet in HEAD
//   mac_rec_error              MAC frame error, sampled in VERIFY
//   local_port                 accepted destination port
//   rd_valid/rd_length/
//   rd_src_ip/rd_src_port      metadata of the oldest pending packet
//   rd_addr, rd_data           payload read port, one cycle latency
//   rd_release                 frees the oldest pending slot
//   drop_cnt                   saturating count of dropped packets
module udp_rx_multibuf #(
   parameter int NUM_BUF     = 4,
   parameter int ADDR_W      = 11,
   parameter int PORT_FILTER = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              udp_rx_req,
   input  logic [7:0]        udp_rx_data,
   input  logic [15:0]       upper_layer_data_length,
   input  logic [7:0]        net_protocol,
   input  logic [31:0]       ip_rec_source_addr,
   input  logic [31:0]       ip_rec_destination_addr,
   input  logic              ip_checksum_error,
   input  logic              ip_addr_check_error,
   input  logic              mac_rec_error,
   input  logic [15:0]       local_port,
   output logic              rd_valid,
   output logic [15:0]       rd_length,
   output logic [31:0]       rd_src_ip,
   output logic [15:0]       rd_src_port,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   input  logic              rd_release,
   output logic [15:0]       drop_cnt
);

   localparam int SLOT_W = $clog2(NUM_BUF);
   localparam int MAX_L  = (1 << ADDR_W) + 8;

   typedef enum logic [2:0] {IDLE, HEAD, DATA, VERIFY, COMMIT, DROP} state_t;
   state_t state_q, state_d;

   logic [15:0]        len_q;
   logic [15:0]        byte_cnt;
   logic [15:0]        src_port_q;
   logic [7:0]         dst_hi_q;
   logic [15:0]        csum_q;
   logic [31:0]        src_ip_q;
   logic [31:0]        sum_q;
   logic [ADDR_W-1:0]  pay_off;
   logic [SLOT_W-1:0]  wr_ptr;
   logic [SLOT_W-1:0]  rd_ptr;
   logic [NUM_BUF-1:0] full_q;

   logic [15:0] len_mem  [NUM_BUF];
   logic [31:0] ip_mem   [NUM_BUF];
   logic [15:0] port_mem [NUM_BUF];
   logic [7:0]  ram      [NUM_BUF * (1 << ADDR_W)];

   logic        last_byte;
   logic        len_bad;
   logic        hdr_fail;
   logic        csum_ok;
   logic [16:0] fold1;
   logic [15:0] fold2;

   assign last_byte = (byte_cnt == len_q - 16'd1);
   assign len_bad   = (len_q < 16'd8) || ({16'd0, len_q} > 32'(MAX_L));

   // The 32-bit accumulator cannot overflow for L <= 65535, so two
   // end-around folds are enough to reach the 16-bit result.
   assign fold1   = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
   assign fold2   = fold1[15:0] + {15'd0, fold1[16]};
   assign csum_ok = (csum_q == 16'h0000) || (fold2 == 16'hFFFF);

   always_comb begin
      hdr_fail = ip_addr_check_error;
      if (byte_cnt == 16'd0 && (len_bad || full_q[wr_ptr]))
         hdr_fail = 1'b1;
      if (PORT_FILTER == 1 && byte_cnt == 16'd3 && {dst_hi_q, udp_rx_data} != local_port)
         hdr_fail = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (udp_rx_req) state_d = HEAD;
         HEAD: begin
            if (ip_checksum_error || hdr_fail) state_d = DROP;
            else if (byte_cnt == 16'd7)        state_d = last_byte ? VERIFY : DATA;
         end
         DATA: begin
            if (ip_checksum_error) state_d = DROP;
            else if (last_byte)    state_d = VERIFY;
         end
         VERIFY:  state_d = (csum_ok && !mac_rec_error) ? COMMIT : DROP;
         COMMIT:  state_d = IDLE;
         DROP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         len_q      <= '0;
         byte_cnt   <= '0;
         src_port_q <= '0;
         dst_hi_q   <= '0;
         csum_q     <= '0;
         src_ip_q   <= '0;
         sum_q      <= '0;
         pay_off    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         full_q     <= '0;
         drop_cnt   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (udp_rx_req) begin
                  len_q    <= upper_layer_data_length;
                  byte_cnt <= '0;
                  pay_off  <= '0;
                  src_ip_q <= ip_rec_source_addr;
                  // Pseudo-header seeds the sum
                  sum_q    <= {16'd0, ip_rec_source_addr[31:16]}
                            + {16'd0, ip_rec_source_addr[15:0]}
                            + {16'd0, ip_rec_destination_addr[31:16]}
                            + {16'd0, ip_rec_destination_addr[15:0]}
                            + {24'd0, net_protocol}
                            + {16'd0, upper_layer_data_length};
               end
            end
            HEAD, DATA: begin
               byte_cnt <= byte_cnt + 16'd1;
               // Even byte index is the high half of a big-endian word; an odd
               // trailing byte therefore lands padded with 8'h00 automatically.
               sum_q <= sum_q + (byte_cnt[0] ? {24'd0, udp_rx_data}
                                             : {16'd0, udp_rx_data, 8'd0});
               if (state_q == HEAD) begin
                  case (byte_cnt[2:0])
                     3'd0:    src_port_q[15:8] <= udp_rx_data;
                     3'd1:    src_port_q[7:0]  <= udp_rx_data;
                     3'd2:    dst_hi_q         <= udp_rx_data;
                     3'd6:    csum_q[15:8]     <= udp_rx_data;
                     3'd7:    csum_q[7:0]      <= udp_rx_data;
                     default: ;
                  endcase
               end else begin
                  pay_off <= pay_off + ADDR_W'(1);
               end
            end
            COMMIT:  wr_ptr <= wr_ptr + SLOT_W'(1);
            DROP:    if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            default: ;
         endcase

         // A committing slot was empty at HEAD start and only COMMIT fills a
         // slot, so it never equals a full read slot: both updates can apply.
         if (rd_release && full_q[rd_ptr]) begin
            full_q[rd_ptr] <= 1'b0;
            rd_ptr         <= rd_ptr + SLOT_W'(1);
         end
         if (state_q == COMMIT)
            full_q[wr_ptr] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == COMMIT) begin
         len_mem[wr_ptr]  <= len_q - 16'd8;
         ip_mem[wr_ptr]   <= src_ip_q;
         port_mem[wr_ptr] <= src_port_q;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == DATA && !ip_checksum_error)
         ram[{wr_ptr, pay_off}] <= udp_rx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= ram[{rd_ptr, rd_addr}];
   end

   // Metadata arrays are not reset; gating with the full flag keeps the
   // outputs at zero whenever no packet is pending.
   assign rd_valid    = full_q[rd_ptr];
   assign rd_length   = rd_valid ? len_mem[rd_ptr]  : 16'd0;
   assign rd_src_ip   = rd_valid ? ip_mem[rd_ptr]   : 32'd0;
   assign rd_src_port = rd_valid ? port_mem[rd_ptr] : 16'd0;

endmodule

// File: tb/tb_udp_rx_multibuf.sv
// tb/tb_udp_rx_multibuf.sv - directed self-checking bench for udp_rx_multibuf
module tb_udp_rx_multibuf;

   localparam int          ADDR_W = 11;
   localparam logic [31:0] SRC_IP = 32'hC0A8_0102;
   localparam logic [31:0] DST_IP = 32'hC0A8_0101;
   localparam logic [15:0] LPORT  = 16'h1F90;
   localparam logic [15:0] SPORT  = 16'h0400;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              udp_rx_req = 1'b0;
   logic [7:0]        udp_rx_data = '0;
   logic [15:0]       upper_layer_data_length = '0;
   logic [7:0]        net_protocol = 8'd17;
   logic [31:0]       ip_rec_source_addr = SRC_IP;
   logic [31:0]       ip_rec_destination_addr = DST_IP;
   logic              ip_checksum_error = 1'b0;
   logic              ip_addr_check_error = 1'b0;
   logic              mac_rec_error = 1'b0;
   logic [15:0]       local_port = LPORT;
   logic              rd_valid;
   logic [15:0]       rd_length;
   logic [31:0]       rd_src_ip;
   logic [15:0]       rd_src_port;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [7:0]        rd_data;
   logic              rd_release = 1'b0;
   logic [15:0]       drop_cnt;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] pkt [64];

   udp_rx_multibuf #(.NUM_BUF(4), .ADDR_W(ADDR_W), .PORT_FILTER(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .udp_rx_req(udp_rx_req), .udp_rx_data(udp_rx_data),
      .upper_layer_data_length(upper_layer_data_length),
      .net_protocol(net_protocol),
      .ip_rec_source_addr(ip_rec_source_addr),
      .ip_rec_destination_addr(ip_rec_destination_addr),
      .ip_checksum_error(ip_checksum_error),
      .ip_addr_check_error(ip_addr_check_error),
      .mac_rec_error(mac_rec_error), .local_port(local_port),
      .rd_valid(rd_valid), .rd_length(rd_length), .rd_src_ip(rd_src_ip),
      .rd_src_port(rd_src_port), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_release(rd_release), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] pay_byte(input logic [7:0] seed, input int k);
      return seed + 8'(k * 5);
   endfunction

   function automatic logic [15:0] calc_csum(input int len);
      logic [31:0] s;
      s = {16'd0, SRC_IP[31:16]} + {16'd0, SRC_IP[15:0]} + {16'd0, DST_IP[31:16]}
        + {16'd0, DST_IP[15:0]} + 32'd17 + 32'(len);
      for (int i = 0; i < len; i += 2)
         s += {16'd0, pkt[i], (i + 1 < len) ? pkt[i+1] : 8'h00};
      while (s[31:16] != 16'd0)
         s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return ~s[15:0];
   endfunction

   // csmode: 0 correct checksum, 1 zero field, 2 wrong nonzero field
   task automatic build(input int len, input logic [15:0] dport, input logic [7:0] seed,
                        input int csmode);
      logic [15:0] l16;
      logic [15:0] c;
      int          n;
      l16 = 16'(len);
      n = (len > 64) ? 8 : len;
      pkt[0] = SPORT[15:8]; pkt[1] = SPORT[7:0];
      pkt[2] = dport[15:8]; pkt[3] = dport[7:0];
      pkt[4] = l16[15:8];   pkt[5] = l16[7:0];
      pkt[6] = 8'h00;       pkt[7] = 8'h00;
      for (int i = 8; i < n; i++) pkt[i] = pay_byte(seed, i - 8);
      c = 16'h0000;
      if (csmode != 1) begin
         c = calc_csum(len);
         if (c == 16'h0000) c = 16'hFFFF;
         if (csmode == 2) begin
            c = c ^ 16'h0001;
            if (c == 16'h0000) c = 16'h0003;
         end
      end
      pkt[6] = c[15:8]; pkt[7] = c[7:0];
   endtask

   // Ends 3 cycles after VERIFY; rel pulses rd_release during the COMMIT cycle.
   task automatic send(input int len, input int nbytes, input int err_at,
                       input bit mac_err, input bit rel);
      @(posedge clk); #1;
      udp_rx_req = 1'b1;
      upper_layer_data_length = 16'(len);
      @(posedge clk); #1;
      udp_rx_req = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
         udp_rx_data = pkt[i];
         ip_checksum_error = (i == err_at);
         @(posedge clk); #1;
      end
      ip_checksum_error = 1'b0;
      mac_rec_error = mac_err;
      @(posedge clk); #1;
      mac_rec_error = 1'b0;
      rd_release = rel;
      @(posedge clk); #1;
      rd_release = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic release_slot();
      rd_release = 1'b1;
      @(posedge clk); #1;
      rd_release = 1'b0;
   endtask

   task automatic chk_meta(input string tag, input logic [15:0] len);
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_len"}, 32'(rd_length), 32'(len));
      chk({tag, "_ip"}, rd_src_ip, SRC_IP);
      chk({tag, "_port"}, 32'(rd_src_port), 32'(SPORT));
   endtask

   task automatic chk_payload(input string tag, input int n, input logic [7:0] seed);
      for (int k = 0; k < n; k++) begin
         rd_addr = ADDR_W'(k);
         @(posedge clk); #1;
         chk($sformatf("%s_data%0d", tag, k), 32'(rd_data), 32'(pay_byte(seed, k)));
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] seeds [4];

      // Reset values
      #1;
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_len", 32'(rd_length), 32'd0);
      chk("rst_ip", rd_src_ip, 32'd0);
      chk("rst_port", 32'(rd_src_port), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      do_reset();

      // Good packet, L=18
      build(18, LPORT, 8'h10, 0);
      send(18, 18, -1, 1'b0, 1'b0);
      chk_meta("good", 16'd10);
      chk_payload("good", 10, 8'h10);
      chk("good_drop", 32'(drop_cnt), 32'd0);
      release_slot();
      chk("good_rel_valid", 32'(rd_valid), 32'd0);

      // Odd length, zero checksum accepted; wrong checksum dropped
      build(13, LPORT, 8'hA3, 1);
      send(13, 13, -1, 1'b0, 1'b0);
      chk_meta("odd", 16'd5);
      chk_payload("odd", 5, 8'hA3);
      release_slot();
      build(13, LPORT, 8'hA3, 2);
      send(13, 13, -1, 1'b0, 1'b0);
      chk("bad_cs_drop", 32'(drop_cnt), 32'd1);
      chk("bad_cs_valid", 32'(rd_valid), 32'd0);

      // Full buffer: five packets, fifth dropped; sixth reuses freed slot
      do_reset();
      for (int p = 0; p < 5; p++) begin
         build(12, LPORT, 8'(8'h40 + p), 0);
         send(12, 12, -1, 1'b0, 1'b0);
      end
      chk("full_drop", 32'(drop_cnt), 32'd1);
      chk_meta("full_p0", 16'd4);
      chk_payload("full_p0", 4, 8'h40);
      release_slot();
      build(12, LPORT, 8'h55, 0);
      send(12, 12, -1, 1'b0, 1'b0);
      chk("full_drop2", 32'(drop_cnt), 32'd1);
      seeds[0] = 8'h41; seeds[1] = 8'h42; seeds[2] = 8'h43; seeds[3] = 8'h55;
      for (int p = 0; p < 4; p++) begin
         chk_meta($sformatf("order%0d", p), 16'd4);
         chk_payload($sformatf("order%0d", p), 4, seeds[p]);
         release_slot();
      end
      chk("full_empty", 32'(rd_valid), 32'd0);

      // Filter and error drops
      do_reset();
      build(18, LPORT + 16'd1, 8'h20, 0);
      send(18, 18, -1, 1'b0, 1'b0);
      chk("port_drop", 32'(drop_cnt), 32'd1);
      build(2057, LPORT, 8'h21, 1);
      send(2057, 8, -1, 1'b0, 1'b0);
      chk("len_drop", 32'(drop_cnt), 32'd2);
      build(18, LPORT, 8'h22, 0);
      send(18, 18, 10, 1'b0, 1'b0);
      chk("ipcs_drop", 32'(drop_cnt), 32'd3);
      build(18, LPORT, 8'h23, 0);
      send(18, 18, -1, 1'b1, 1'b0);
      chk("mac_drop", 32'(drop_cnt), 32'd4);
      chk("err_valid", 32'(rd_valid), 32'd0);

      // COMMIT and rd_release on the same cycle with 3 pending
      do_reset();
      for (int p = 0; p < 3; p++) begin
         build(12, LPORT, 8'(8'h31 + p), 0);
         send(12, 12, -1, 1'b0, 1'b0);
      end
      build(12, LPORT, 8'h34, 0);
      send(12, 12, -1, 1'b0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         chk_meta($sformatf("simul%0d", p), 16'd4);
         chk_payload($sformatf("simul%0d", p), 4, 8'(8'h32 + p));
         release_slot();
      end
      chk("simul_empty", 32'(rd_valid), 32'd0);

      // Reset in the middle of a payload
      build(18, LPORT, 8'h60, 0);
      send(18, 18, -1, 1'b0, 1'b0);
      build(18, LPORT + 16'd2, 8'h61, 0);
      send(18, 18, -1, 1'b0, 1'b0);
      chk("pre_rst_valid", 32'(rd_valid), 32'd1);
      chk("pre_rst_drop", 32'(drop_cnt), 32'd1);
      build(18, LPORT, 8'h62, 0);
      @(posedge clk); #1;
      udp_rx_req = 1'b1;
      upper_layer_data_length = 16'd18;
      @(posedge clk); #1;
      udp_rx_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
         udp_rx_data = pkt[i];
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #2;
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      release_slot();
      build(18, LPORT, 8'h99, 0);
      send(18, 18, -1, 1'b0, 1'b0);
      chk_meta("post_rst", 16'd10);
      chk_payload("post_rst", 10, 8'h99);
      chk("post_rst_drop", 32'(drop_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
